rv32_mem_responder: RTL and testbench
=====================================

// Module: rv32_mem_responder
// PURPOSE
//  Word-addressed memory responder for the RV32I core's load/store and fetch bus.
//  Accepts one request at a time over a valid/ready request channel and returns
//  read data or a write acknowledgement on a valid/ready response channel.
//  Supports byte enables, programmable wait states and an address-fault flag.
//  Sits between the core's memory initiator port and on-chip storage.
// PARAMETERS
//  DEPTH_WORDS  256     number of 32-bit words stored (power of two, >=4)
//  BASE_ADDR    32'h0   byte address of word 0 (DEPTH_WORDS*4 aligned)
//  WAIT_CYCLES  1       extra cycles between accept and response (0..15)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept a request this cycle
//  req_we     in   1   1 = write, 0 = read
//  req_addr   in   32  byte address
//  req_wdata  in   32  write data, little-endian lanes
//  req_be     in   4   byte enables; bit i enables wdata[8i+7:8i]
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   initiator accepts response
//  rsp_rdata  out  32  read data (0 for writes and faults)
//  rsp_err    out  1   address fault on this transaction
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    wait counter=0. Storage array is NOT reset (contents retained/undefined).
//  - FSM states: IDLE -> (WAIT_CYCLES>0 ? WAIT : RESP) on accept;
//    WAIT -> RESP when counter reaches WAIT_CYCLES-1; RESP -> IDLE on rsp_ready.
//  - req_ready = (state==IDLE), combinational from state only.
//  - Accept = req_valid & req_ready at a rising edge; latch we/addr/wdata/be.
//    While not in IDLE, request inputs are ignored.
//  - Fault: addr[1:0]!=0, addr<BASE_ADDR, or (addr-BASE_ADDR)>>2 >= DEPTH_WORDS.
//    Faulted transactions: no storage write, rsp_rdata=0, rsp_err=1.
//  - Access performed on the edge entering RESP: write updates only enabled
//    lanes; read captures the full word into rsp_rdata. Write rsp_rdata=0.
//  - Write with req_be=4'b0000: no storage change, rsp_err=0 (legal no-op).
//  - Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge.
//  - rsp_valid, rsp_rdata, rsp_err are registered and held stable while
//    rsp_valid & ~rsp_ready (backpressure); cleared to 0 on the handshake edge.
//  - Back-to-back: after response handshake, req_ready=1 next cycle; minimum
//    request spacing is WAIT_CYCLES+2 cycles. No same-cycle accept in RESP.
//  - Read-after-write to same word returns the merged new value.
//  - Address offset arithmetic is 32-bit unsigned; index = offset[log2(D)+1:2].
//  - rst asserted mid-transaction: transaction abandoned, outputs to reset
//    values; a write not yet at its RESP-entry edge does not occur.
// TESTING
//  1 Write addr=BASE+0x10 wdata=32'hDEADBEEF be=4'hF, then read same ->
//    rsp_rdata=32'hDEADBEEF, rsp_err=0, rsp_valid WAIT_CYCLES+1 cycles after accept.
//  2 Over 1, write wdata=32'h000000AA be=4'b0001, read -> 32'hDEADBEAA;
//    write be=4'b0000 then read -> unchanged 32'hDEADBEAA.
//  3 Read addr=BASE+0x13 and addr=BASE+DEPTH_WORDS*4 -> rsp_err=1, rdata=0;
//    write to BASE+0x2 -> rsp_err=1, subsequent read of BASE+0x0 unchanged.
//  4 Hold rsp_ready=0 for 5 cycles on a read -> rsp_valid/rdata/err stable,
//    req_ready=0 throughout; req_valid pulses during stall are not accepted.
//  5 Assert rst one cycle after accepting a write of 32'h12345678 to BASE+0x20
//    (WAIT_CYCLES=3) -> rsp_valid=0, req_ready=1 next; read shows old value.
//  6 Sweep WAIT_CYCLES=0 and 15 with back-to-back reads, rsp_ready tied 1 ->
//    latency 1 and 16 cycles, spacing 2 and 17 cycles between accepts.

Source files
------------

// File: rtl/rv32_mem_responder.sv
// rv32_mem_responder: single-outstanding word memory responder for the RV32I
// core's load/store and fetch bus. One request is accepted from IDLE, held for
// a programmable number of wait states, then answered on the response channel
// with read data or a write acknowledgement plus an address-fault flag.
module rv32_mem_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_be;

   logic [31:0] mem [DEPTH_WORDS];

   logic             acc_we;
   logic [31:0]      acc_addr;
   logic [31:0]      acc_wdata;
   logic [3:0]       acc_be;
   logic [31:0]      acc_offset;
   logic [IDX_W-1:0] acc_idx;
   logic             acc_fault;
   logic             enter_resp;
   logic [31:0]      rd_value;

   assign req_ready = (state == IDLE);

   // Select the transaction being serviced (live inputs in IDLE so a zero-wait access can complete on the accept edge), decode it and flag the RESP-entry edge.
   always_comb begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
      if (state == IDLE) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end
      acc_offset = acc_addr - BASE_ADDR;
      acc_idx    = acc_offset[IDX_W+1:2];
      acc_fault  = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                   ((acc_offset >> 2) >= DEPTH_L);
      enter_resp = 1'b0;
      if (state == IDLE) begin
         enter_resp = req_valid && (WAIT_CYCLES == 0);
      end else if (state == WAIT) begin
         enter_resp = (wait_cnt == WAIT_LAST);
      end
      rd_value = (acc_we || acc_fault) ? 32'h0 : mem[acc_idx];
   end

   // Storage write on the RESP-entry edge, enabled lanes only; no reset on the array and no write while reset is held.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && acc_we && !acc_fault) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   // Request/response FSM with registered response outputs held under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         lat_we    <= 1'b0;
         lat_addr  <= 32'h0;
         lat_wdata <= 32'h0;
         lat_be    <= 4'h0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_be    <= req_be;
                  wait_cnt  <= 4'd0;
                  if (WAIT_CYCLES == 0) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rd_value;
                     rsp_err   <= acc_fault;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (enter_resp) begin
                  state     <= RESP;
                  wait_cnt  <= 4'd0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rd_value;
                  rsp_err   <= acc_fault;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'h0;
                  rsp_err   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_mem_responder.sv
// tb_rv32_mem_responder: scoreboard bench for rv32_mem_responder. A main
// instance (WAIT_CYCLES=3, BASE 0x1000) covers data, faults, backpressure and
// mid-transaction reset; two lane instances (WAIT_CYCLES=0 and 15) cover
// latency and back-to-back request spacing.
module tb_rv32_mem_responder;

   localparam int          MAIN_WAIT = 3;
   localparam logic [31:0] BASE      = 32'h0000_1000;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [3:0]  req_be = 4'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic        l_req_valid [2];
   logic        l_req_ready [2];
   logic        l_req_we    [2];
   logic [31:0] l_req_addr  [2];
   logic [31:0] l_req_wdata [2];
   logic [3:0]  l_req_be    [2];
   logic        l_rsp_valid [2];
   logic [31:0] l_rsp_rdata [2];
   logic        l_rsp_err   [2];
   int          l_rsp_cnt   [2];
   int          l_acc_cnt   [2];

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   int   acc_q[$];

   bit          seen = 1'b0;
   int          first_cyc = 0;
   logic [31:0] hold_rdata = 32'h0;
   logic        hold_err = 1'b0;

   rv32_mem_responder #(
      .DEPTH_WORDS(256),
      .BASE_ADDR(BASE),
      .WAIT_CYCLES(MAIN_WAIT)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_be(req_be),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Edge counter: at a negedge, cyc is the number of the most recent rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Issue one request on the main instance and queue its expected response.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
      bit got;
      exp_q.push_back('{rdata: exp_rdata, err: exp_err});
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (req_ready) got = 1'b1;
      end
      if (got) begin
         acc_q.push_back(cyc + 1);
      end else begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: addr %h never accepted", addr);
         void'(exp_q.pop_back());
      end
      @(posedge clk) #1;
      req_valid = 1'b0;
   endtask

   // Wait (bounded) until every queued response has been handshaken.
   task automatic waitIdle();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !rsp_valid) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL idle_timeout: %0d responses outstanding", exp_q.size());
         exp_q.delete();
         acc_q.delete();
      end
      @(posedge clk) #1;
   endtask

   // Monitor: track first-valid cycle, check hold-stability under backpressure and pop/compare on handshake.
   always @(negedge clk) begin
      if (rst) begin
         seen = 1'b0;
      end else if (rsp_valid) begin
         if (!seen) begin
            seen       = 1'b1;
            first_cyc  = cyc;
            hold_rdata = rsp_rdata;
            hold_err   = rsp_err;
         end else begin
            checkOutput("stall_rdata", rsp_rdata, hold_rdata);
            checkOutput("stall_err", {31'h0, rsp_err}, {31'h0, hold_err});
         end
         checkOutput("req_ready_busy", {31'h0, req_ready}, 32'h0);
         if (rsp_ready) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_rsp: got rdata %h err %b with nothing expected", rsp_rdata, rsp_err);
            end else begin
               exp_t e;
               int   a;
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               checkOutput("rsp_rdata", rsp_rdata, e.rdata);
               checkOutput("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
               checkOutput("rsp_latency", first_cyc - a + 1, MAIN_WAIT + 1);
            end
            seen = 1'b0;
         end
      end
   end

   // Latency/spacing lanes at the two wait-state extremes with rsp_ready tied high.
   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int          LW    = (g == 0) ? 0 : 15;
      localparam logic [31:0] LDATA = (g == 0) ? 32'h0BAD_F00D : 32'h7E57_CAFE;
      int last_acc = 0;

      rv32_mem_responder #(
         .DEPTH_WORDS(256),
         .BASE_ADDR(32'h0),
         .WAIT_CYCLES(LW)
      ) u_lane (
         .clk(clk),
         .rst(rst),
         .req_valid(l_req_valid[g]),
         .req_ready(l_req_ready[g]),
         .req_we(l_req_we[g]),
         .req_addr(l_req_addr[g]),
         .req_wdata(l_req_wdata[g]),
         .req_be(l_req_be[g]),
         .rsp_valid(l_rsp_valid[g]),
         .rsp_ready(1'b1),
         .rsp_rdata(l_rsp_rdata[g]),
         .rsp_err(l_rsp_err[g])
      );

      // Lane monitor: spacing between accepts, latency to first valid, and response contents.
      always @(negedge clk) begin
         if (!rst) begin
            if (l_req_valid[g] && l_req_ready[g]) begin
               if (l_acc_cnt[g] > 0) checkOutput("lane_spacing", cyc + 1 - last_acc, LW + 2);
               last_acc = cyc + 1;
               l_acc_cnt[g]++;
            end
            if (l_rsp_valid[g]) begin
               checkOutput("lane_latency", cyc - last_acc + 1, LW + 1);
               checkOutput("lane_rdata", l_rsp_rdata[g], (l_rsp_cnt[g] == 0) ? 32'h0 : LDATA);
               checkOutput("lane_err", {31'h0, l_rsp_err[g]}, 32'h0);
               l_rsp_cnt[g]++;
            end
         end
      end
   end

   // One write then three back-to-back reads of the same word on a lane.
   task automatic laneRun(input int g, input logic [31:0] data);
      bit got;
      for (int k = 0; k < 4; k++) begin
         l_req_valid[g] = 1'b1;
         l_req_we[g]    = (k == 0);
         l_req_addr[g]  = 32'h40;
         l_req_wdata[g] = (k == 0) ? data : 32'h0;
         l_req_be[g]    = 4'hF;
         got = 1'b0;
         for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (l_req_ready[g]) got = 1'b1;
         end
         if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL lane_accept_timeout: lane %0d request %0d", g, k);
         end
         @(posedge clk) #1;
      end
      l_req_valid[g] = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      checkOutput("lane_rsp_count", l_rsp_cnt[g], 4);
      checkOutput("lane_acc_count", l_acc_cnt[g], 4);
   endtask

   // Directed test sequence.
   initial begin
      for (int g = 0; g < 2; g++) begin
         l_req_valid[g] = 1'b0;
         l_req_we[g]    = 1'b0;
         l_req_addr[g]  = 32'h0;
         l_req_wdata[g] = 32'h0;
         l_req_be[g]    = 4'h0;
         l_rsp_cnt[g]   = 0;
         l_acc_cnt[g]   = 0;
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
      @(posedge clk) #1;
      rst = 1'b0;
      @(posedge clk) #1;

      $display("[TB] full-word write and read back");
      applyStimulus(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
      applyStimulus(1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);

      $display("[TB] byte-lane merge and empty-enable write");
      applyStimulus(1'b1, BASE + 32'h10, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0);
      applyStimulus(1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEAD_BEAA, 1'b0);
      applyStimulus(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
      applyStimulus(1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEAD_BEAA, 1'b0);
      applyStimulus(1'b1, BASE + 32'h10, 32'h1122_0000, 4'b1100, 32'h0, 1'b0);
      applyStimulus(1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'h1122_BEAA, 1'b0);

      $display("[TB] address faults and top word");
      applyStimulus(1'b1, BASE, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
      applyStimulus(1'b0, BASE + 32'h13, 32'h0, 4'hF, 32'h0, 1'b1);
      applyStimulus(1'b0, BASE + 32'h400, 32'h0, 4'hF, 32'h0, 1'b1);
      applyStimulus(1'b0, BASE - 32'h4, 32'h0, 4'hF, 32'h0, 1'b1);
      applyStimulus(1'b1, BASE + 32'h2, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
      applyStimulus(1'b1, BASE + 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
      applyStimulus(1'b0, BASE, 32'h0, 4'hF, 32'h1122_3344, 1'b0);
      applyStimulus(1'b1, BASE + 32'h3FC, 32'hA1B2_C3D4, 4'hF, 32'h0, 1'b0);
      applyStimulus(1'b0, BASE + 32'h3FC, 32'h0, 4'hF, 32'hA1B2_C3D4, 1'b0);
      waitIdle();

      $display("[TB] response backpressure");
      applyStimulus(1'b1, BASE + 32'h30, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0);
      waitIdle();
      rsp_ready = 1'b0;
      applyStimulus(1'b0, BASE + 32'h30, 32'h0, 4'hF, 32'h55AA_55AA, 1'b0);
      for (int t = 0; t < 50 && !rsp_valid; t++) @(negedge clk);
      for (int t = 0; t < 5; t++) begin
         @(posedge clk) #1;
         req_valid = (t % 2 == 0);
         req_we    = 1'b1;
         req_addr  = BASE + 32'h30;
         req_wdata = 32'h0;
         req_be    = 4'hF;
      end
      @(posedge clk) #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      waitIdle();
      applyStimulus(1'b0, BASE + 32'h30, 32'h0, 4'hF, 32'h55AA_55AA, 1'b0);
      waitIdle();

      $display("[TB] reset during a pending write");
      applyStimulus(1'b1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
      waitIdle();
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = BASE + 32'h20;
      req_wdata = 32'h1234_5678;
      req_be    = 4'hF;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      @(posedge clk) #1;
      req_valid = 1'b0;
      @(posedge clk) #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      checkOutput("midrst_req_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk) #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postrst_req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("postrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      @(posedge clk) #1;
      applyStimulus(1'b0, BASE + 32'h20, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0);
      waitIdle();

      $display("[TB] latency and spacing at zero and fifteen wait states");
      laneRun(0, 32'h0BAD_F00D);
      laneRun(1, 32'h7E57_CAFE);

      checkOutput("scoreboard_empty", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
